// File: rtl/conv_layer_scheduler.sv
// Sequences NUM_LAYERS conv passes over a ping-pong buffer pair, launching the
// engine once per layer and guarding each pass with a timeout.
module conv_layer_scheduler #(
  parameter int unsigned NUM_LAYERS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  localparam int unsigned LAYER_W       = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int unsigned TMO_W         = $clog2(TIMEOUT_CYCLES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  output logic               eng_enable,
  input  logic               eng_done,
  output logic               rd_bank,
  output logic               wr_bank,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [31:0]        cycle_count
);

  typedef enum logic [2:0] {StIdle, StLaunch, StWait, StSwap, StFinish, StError} state_e;

  state_e             state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic               rd_bank_q, rd_bank_d;
  logic               error_q, error_d;
  logic [31:0]        cyc_q, cyc_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  always_comb begin
    state_d   = state_q;
    layer_d   = layer_q;
    rd_bank_d = rd_bank_q;
    error_d   = error_q;
    cyc_d     = cyc_q;
    tmo_d     = tmo_q;

    if (state_q != StIdle && cyc_q != 32'hFFFF_FFFF) begin
      cyc_d = cyc_q + 32'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StLaunch;
          layer_d   = '0;
          rd_bank_d = 1'b0;
          error_d   = 1'b0;
          cyc_d     = '0;
        end
      end
      StLaunch: begin
        tmo_d   = '0;
        state_d = abort ? StIdle : StWait;
      end
      StWait: begin
        tmo_d = tmo_q + TMO_W'(1);
        // Completion beats a coincident timeout.
        if (abort) begin
          state_d = StIdle;
        end else if (eng_done) begin
          state_d = StSwap;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = StError;
          error_d = 1'b1;
        end
      end
      StSwap: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          rd_bank_d = ~rd_bank_q;
          if (layer_q == LAYER_W'(NUM_LAYERS - 1)) begin
            state_d = StFinish;
          end else begin
            layer_d = layer_q + LAYER_W'(1);
            state_d = StLaunch;
          end
        end
      end
      StFinish: state_d = StIdle;
      StError:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      layer_q   <= '0;
      rd_bank_q <= 1'b0;
      error_q   <= 1'b0;
      cyc_q     <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      layer_q   <= layer_d;
      rd_bank_q <= rd_bank_d;
      error_q   <= error_d;
      cyc_q     <= cyc_d;
      tmo_q     <= tmo_d;
    end
  end

  assign eng_enable  = (state_q == StLaunch);
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StFinish);
  assign error       = error_q;
  assign rd_bank     = rd_bank_q;
  assign wr_bank     = ~rd_bank_q;
  assign layer_idx   = layer_q;
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Bench for conv_layer_scheduler: table of runs against a responding engine model,
// launch scoreboard, plus reset, abort and ignored-input sequences.
module tb_conv_layer_scheduler;

  localparam int unsigned NL = 3;
  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset, start, abort, eng_done;
  logic        eng_enable, rd_bank, wr_bank, busy, done, error;
  logic [1:0]  layer_idx;
  logic [31:0] cycle_count;

  always #5 clk = ~clk;

  conv_layer_scheduler #(
    .NUM_LAYERS     (NL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .eng_enable  (eng_enable),
    .eng_done    (eng_done),
    .rd_bank     (rd_bank),
    .wr_bank     (wr_bank),
    .layer_idx   (layer_idx),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .cycle_count (cycle_count)
  );

  typedef struct {
    int lat;
    bit mute;
    int abort_layer;
    bit hold_start;
    bit inj_launch_done;
    int exp_launch;
    int exp_done;
    bit exp_error;
    int exp_layer;
    bit exp_rd;
    int exp_cycles;
  } vec_t;

  typedef struct {
    int layer;
    bit rd;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  int n_vec = 0;
  int n_fail = 0;
  int busy_seen, done_seen, launches;
  int eng_cnt = 0;
  int lat = 5;
  bit mute = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle: observe outputs at the falling edge, then step the engine model.
  task automatic tick();
    exp_t e;
    logic exp_wr;
    @(negedge clk);
    if (busy) busy_seen++;
    if (done) done_seen++;
    exp_wr = ~rd_bank;
    check("bank_pair", wr_bank, exp_wr);
    if (eng_enable) begin
      launches++;
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_launch: layer %0d, no launch expected", layer_idx);
      end else begin
        e = sb.pop_front();
        check("launch_layer", layer_idx, e.layer);
        check("launch_rd_bank", rd_bank, e.rd);
      end
    end
    eng_done = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) eng_done = 1'b1;
    end
    if (eng_enable && !mute) eng_cnt = lat;
  endtask

  task automatic push_launches(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.layer = i;
      e.rd    = i[0];
      sb.push_back(e);
    end
  endtask

  task automatic idle_check(input bit exp_err);
    int d0, l0;
    logic [31:0] c0;
    d0 = done_seen;
    l0 = launches;
    c0 = cycle_count;
    repeat (12) tick();
    check("idle_no_done", done_seen, d0);
    check("idle_no_launch", launches, l0);
    check("idle_cycle_hold", cycle_count, c0);
    check("idle_busy", busy, 0);
    check("idle_error_sticky", error, exp_err);
  endtask

  task automatic run_vec(input vec_t v);
    int arm;
    bit ok;
    lat  = v.lat;
    mute = v.mute;
    push_launches(v.exp_launch);
    busy_seen = 0;
    done_seen = 0;
    launches  = 0;
    start = 1'b1;
    tick();
    start = v.hold_start;
    check("start_latency", eng_enable, 1);
    check("error_cleared", error, 0);
    check("count_cleared", cycle_count, 0);
    if (v.inj_launch_done) eng_done = 1'b1;
    arm = 0;
    ok  = 1'b0;
    for (int g = 0; g < 400; g++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      abort = 1'b0;
      if (arm != 0) begin
        abort = 1'b1;
        arm   = 0;
      end
      if (eng_enable && v.abort_layer >= 0 && int'(layer_idx) == v.abort_layer) arm = 1;
      tick();
    end
    abort = 1'b0;
    start = 1'b0;
    check("run_terminates", ok, 1);
    check("launch_count", launches, v.exp_launch);
    check("done_count", done_seen, v.exp_done);
    check("error_end", error, v.exp_error);
    check("layer_end", layer_idx, v.exp_layer);
    check("rd_bank_end", rd_bank, v.exp_rd);
    check("cycles_expected", cycle_count, v.exp_cycles);
    check("cycles_vs_busy", cycle_count, busy_seen);
    check("scoreboard_drained", sb.size(), 0);
    sb.delete();
    idle_check(v.exp_error);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0, l0;
    bit ok;
    logic [31:0] c0;

    vecs[0] = '{lat:5, mute:0, abort_layer:-1, hold_start:0, inj_launch_done:0,
                exp_launch:3, exp_done:1, exp_error:0, exp_layer:2, exp_rd:1, exp_cycles:22};
    vecs[1] = '{lat:5, mute:1, abort_layer:-1, hold_start:0, inj_launch_done:0,
                exp_launch:1, exp_done:0, exp_error:1, exp_layer:0, exp_rd:0, exp_cycles:18};
    vecs[2] = '{lat:1, mute:0, abort_layer:-1, hold_start:0, inj_launch_done:1,
                exp_launch:3, exp_done:1, exp_error:0, exp_layer:2, exp_rd:1, exp_cycles:10};
    vecs[3] = '{lat:5, mute:0, abort_layer:1, hold_start:0, inj_launch_done:0,
                exp_launch:2, exp_done:0, exp_error:0, exp_layer:1, exp_rd:1, exp_cycles:9};
    vecs[4] = '{lat:16, mute:0, abort_layer:-1, hold_start:0, inj_launch_done:0,
                exp_launch:3, exp_done:1, exp_error:0, exp_layer:2, exp_rd:1, exp_cycles:55};
    vecs[5] = '{lat:2, mute:0, abort_layer:-1, hold_start:1, inj_launch_done:0,
                exp_launch:3, exp_done:1, exp_error:0, exp_layer:2, exp_rd:1, exp_cycles:13};

    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    eng_done = 1'b0;
    busy_seen = 0;
    done_seen = 0;
    launches  = 0;
    tick();
    tick();
    check("rst_eng_enable", eng_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_rd_bank", rd_bank, 0);
    check("rst_wr_bank", wr_bank, 1);
    check("rst_layer", layer_idx, 0);
    check("rst_cycles", cycle_count, 0);
    reset = 1'b0;
    repeat (3) tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Engine completion while idle must not disturb anything.
    c0 = cycle_count;
    eng_done = 1'b1;
    tick();
    tick();
    check("idle_done_busy", busy, 0);
    check("idle_done_cycles", cycle_count, c0);
    check("idle_done_layer", layer_idx, 2);

    // Reset during the WAIT of the last layer.
    lat  = 5;
    mute = 1'b0;
    push_launches(3);
    done_seen = 0;
    launches  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    for (int g = 0; g < 200; g++) begin
      if (eng_enable && layer_idx == 2'd2) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("reach_layer2", ok, 1);
    tick();
    tick();
    check("pre_reset_wait", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_eng_enable", eng_enable, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_rd_bank", rd_bank, 0);
    check("mid_rst_wr_bank", wr_bank, 1);
    check("mid_rst_layer", layer_idx, 0);
    check("mid_rst_cycles", cycle_count, 0);
    tick();
    check("mid_rst_hold_busy", busy, 0);
    reset = 1'b0;
    sb.delete();
    d0 = done_seen;
    l0 = launches;
    repeat (12) tick();
    check("post_rst_no_done", done_seen, d0);
    check("post_rst_no_launch", launches, l0);
    check("post_rst_idle", busy, 0);

    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
